// File: rtl/lifo_ctl.sv
// Command front end for the lifo_se register stack: tracks live depth, issues only
// safe stack effects, and latches sticky under/overflow errors until cleared.
module lifo_ctl #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 12,
   localparam int DW    = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_data,
   output logic [2:0]       o_se,
   output logic [WIDTH-1:0] o_data,
   output logic [DW-1:0]    o_depth,
   output logic [DW-1:0]    o_hwm,
   output logic             o_underflow,
   output logic             o_overflow,
   output logic [2:0]       o_err_op,
   input  logic             i_clr_err
);

   localparam logic [2:0] SE_NONE = 3'd0;
   localparam logic [2:0] SE_DROP = 3'd1;
   localparam logic [2:0] SE_PUSH = 3'd2;
   localparam logic [2:0] SE_RPLC = 3'd3;
   localparam logic [2:0] SE_SWAP = 3'd4;
   localparam logic [2:0] SE_ROT3 = 3'd5;
   localparam logic [2:0] SE_RROT = 3'd6;
   localparam logic [2:0] SE_ALU2 = 3'd7;

   logic          accept;
   logic          legal;
   logic          is_push;
   logic [DW-1:0] next_depth;

   assign o_ready = !(o_underflow | o_overflow) & !i_clr_err;
   assign accept  = i_valid & o_ready;
   assign is_push = (i_op == SE_PUSH);

   // Legality depends only on the depth before the request; illegal ops never move
   // the counter, which is what keeps it from wrapping.
   always_comb begin
      legal      = 1'b0;
      next_depth = o_depth;
      case (i_op)
         SE_NONE: legal = 1'b1;
         SE_DROP: begin
            legal      = (o_depth >= DW'(1));
            next_depth = o_depth - DW'(1);
         end
         SE_PUSH: begin
            legal      = (o_depth < DW'(DEPTH));
            next_depth = o_depth + DW'(1);
         end
         SE_RPLC: legal = (o_depth >= DW'(1));
         SE_SWAP: legal = (o_depth >= DW'(2));
         SE_ROT3: legal = (o_depth >= DW'(3));
         SE_RROT: legal = (o_depth >= DW'(3));
         SE_ALU2: begin
            legal      = (o_depth >= DW'(2));
            next_depth = o_depth - DW'(1);
         end
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_se        <= SE_NONE;
         o_data      <= '0;
         o_depth     <= '0;
         o_hwm       <= '0;
         o_underflow <= 1'b0;
         o_overflow  <= 1'b0;
         o_err_op    <= SE_NONE;
      end else begin
         o_se <= SE_NONE;
         if (i_clr_err) begin
            o_underflow <= 1'b0;
            o_overflow  <= 1'b0;
            o_err_op    <= SE_NONE;
            o_hwm       <= o_depth;
         end else if (accept) begin
            if (legal) begin
               o_se    <= i_op;
               o_data  <= i_data;
               o_depth <= next_depth;
               if (next_depth > o_hwm)
                  o_hwm <= next_depth;
            end else begin
               // Accept implies no flag is set yet, so this is always the first fault.
               if (is_push)
                  o_overflow <= 1'b1;
               else
                  o_underflow <= 1'b1;
               if (!(o_underflow | o_overflow))
                  o_err_op <= i_op;
            end
         end
      end
   end

endmodule

// File: tb/tb_lifo_ctl.sv
// Self-checking bench for lifo_ctl: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based stack model.
module tb_lifo_ctl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 12;
   localparam int DW    = $clog2(DEPTH + 1);

   localparam logic [2:0] NONE = 3'd0;
   localparam logic [2:0] DROP = 3'd1;
   localparam logic [2:0] PUSH = 3'd2;
   localparam logic [2:0] RPLC = 3'd3;
   localparam logic [2:0] SWAP = 3'd4;
   localparam logic [2:0] ROT3 = 3'd5;
   localparam logic [2:0] RROT = 3'd6;
   localparam logic [2:0] ALU2 = 3'd7;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic             i_valid;
   logic             o_ready;
   logic [2:0]       i_op;
   logic [WIDTH-1:0] i_data;
   logic [2:0]       o_se;
   logic [WIDTH-1:0] o_data;
   logic [DW-1:0]    o_depth;
   logic [DW-1:0]    o_hwm;
   logic             o_underflow;
   logic             o_overflow;
   logic [2:0]       o_err_op;
   logic             i_clr_err;

   int checks = 0;
   int errors = 0;

   lifo_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_op        (i_op),
      .i_data      (i_data),
      .o_se        (o_se),
      .o_data      (o_data),
      .o_depth     (o_depth),
      .o_hwm       (o_hwm),
      .o_underflow (o_underflow),
      .o_overflow  (o_overflow),
      .o_err_op    (o_err_op),
      .i_clr_err   (i_clr_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic       valid;
      logic       clr;
      logic [2:0] op;
      logic [7:0] data;
      logic       exp_ready;
      logic [2:0] exp_se;
      logic [7:0] exp_data;
      int         exp_depth;
      int         exp_hwm;
      logic       exp_uf;
      logic       exp_of;
      logic [2:0] exp_err;
   } vec_t;

   vec_t vecs[13];

   // Reference model: the stack itself is a queue, depth is its size.
   logic [7:0] m_stk[$];
   int         m_hwm;
   logic       m_uf, m_of;
   logic [2:0] m_err, m_se;
   logic [7:0] m_data;
   int         need[8] = '{0, 1, 0, 1, 2, 3, 3, 2};

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic [2:0] se, input logic [7:0] data,
                           input int depth, input int hwm, input logic uf, input logic of_,
                           input logic [2:0] err);
      checkOutput({tag, " se"}, 32'(o_se), 32'(se));
      checkOutput({tag, " data"}, 32'(o_data), 32'(data));
      checkOutput({tag, " depth"}, 32'(o_depth), 32'(depth));
      checkOutput({tag, " hwm"}, 32'(o_hwm), 32'(hwm));
      checkOutput({tag, " underflow"}, 32'(o_underflow), 32'(uf));
      checkOutput({tag, " overflow"}, 32'(o_overflow), 32'(of_));
      checkOutput({tag, " err_op"}, 32'(o_err_op), 32'(err));
   endtask

   // Drives one cycle of inputs, checks ready before the edge, leaves time at edge+1.
   task automatic applyStimulus(input logic valid, input logic clr, input logic [2:0] op,
                                input logic [7:0] data, input string tag, input logic exp_ready);
      i_valid   = valid;
      i_clr_err = clr;
      i_op      = op;
      i_data    = data;
      #1;
      checkOutput({tag, " ready"}, 32'(o_ready), 32'(exp_ready));
      @(posedge i_clk);
      #1;
   endtask

   task automatic modelReset();
      m_stk.delete();
      m_hwm  = 0;
      m_uf   = 1'b0;
      m_of   = 1'b0;
      m_err  = NONE;
      m_se   = NONE;
      m_data = '0;
   endtask

   task automatic modelStep(input logic valid, input logic clr, input logic [2:0] op,
                            input logic [7:0] data);
      logic [7:0] t;
      m_se = NONE;
      if (clr) begin
         m_uf  = 1'b0;
         m_of  = 1'b0;
         m_err = NONE;
         m_hwm = m_stk.size();
      end else if (valid && !(m_uf || m_of)) begin
         if (op == PUSH && m_stk.size() == DEPTH) begin
            m_of  = 1'b1;
            m_err = op;
         end else if (m_stk.size() < need[op]) begin
            m_uf  = 1'b1;
            m_err = op;
         end else begin
            m_se   = op;
            m_data = data;
            case (op)
               DROP: void'(m_stk.pop_front());
               PUSH: m_stk.push_front(data);
               RPLC: m_stk[0] = data;
               SWAP: begin t = m_stk[0]; m_stk[0] = m_stk[1]; m_stk[1] = t; end
               ROT3: begin t = m_stk[2]; m_stk.delete(2); m_stk.push_front(t); end
               RROT: begin t = m_stk.pop_front(); m_stk.insert(2, t); end
               ALU2: begin void'(m_stk.pop_front()); m_stk[0] = data; end
               default: ;
            endcase
            if (m_stk.size() > m_hwm) m_hwm = m_stk.size();
         end
      end
   endtask

   task automatic doReset();
      i_rst     = 1'b1;
      i_valid   = 1'b0;
      i_clr_err = 1'b0;
      i_op      = NONE;
      i_data    = '0;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      #1;
   endtask

   initial begin
      logic       v, c;
      logic [2:0] op;
      logic [7:0] d;
      logic       exp_rdy;

      vecs[0]  = '{1, 0, PUSH, 8'h11, 1, PUSH, 8'h11, 1, 1, 0, 0, NONE};
      vecs[1]  = '{1, 0, PUSH, 8'h22, 1, PUSH, 8'h22, 2, 2, 0, 0, NONE};
      vecs[2]  = '{1, 0, PUSH, 8'h33, 1, PUSH, 8'h33, 3, 3, 0, 0, NONE};
      vecs[3]  = '{1, 0, SWAP, 8'h00, 1, SWAP, 8'h00, 3, 3, 0, 0, NONE};
      vecs[4]  = '{1, 0, ROT3, 8'h00, 1, ROT3, 8'h00, 3, 3, 0, 0, NONE};
      vecs[5]  = '{1, 0, ALU2, 8'h55, 1, ALU2, 8'h55, 2, 3, 0, 0, NONE};
      vecs[6]  = '{0, 0, PUSH, 8'h99, 1, NONE, 8'h55, 2, 3, 0, 0, NONE};
      vecs[7]  = '{1, 0, DROP, 8'h00, 1, DROP, 8'h00, 1, 3, 0, 0, NONE};
      vecs[8]  = '{1, 0, DROP, 8'h00, 1, DROP, 8'h00, 0, 3, 0, 0, NONE};
      vecs[9]  = '{1, 0, DROP, 8'h44, 1, NONE, 8'h00, 0, 3, 1, 0, DROP};
      vecs[10] = '{1, 0, PUSH, 8'h77, 0, NONE, 8'h00, 0, 3, 1, 0, DROP};
      vecs[11] = '{1, 1, PUSH, 8'h77, 0, NONE, 8'h00, 0, 0, 0, 0, NONE};
      vecs[12] = '{1, 0, PUSH, 8'h77, 1, PUSH, 8'h77, 1, 1, 0, 0, NONE};

      doReset();
      checkAll("reset", NONE, 8'h00, 0, 0, 1'b0, 1'b0, NONE);
      checkOutput("reset ready", 32'(o_ready), 32'd1);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].valid, vecs[i].clr, vecs[i].op, vecs[i].data,
                       $sformatf("vec%0d", i), vecs[i].exp_ready);
         checkAll($sformatf("vec%0d", i), vecs[i].exp_se, vecs[i].exp_data, vecs[i].exp_depth,
                  vecs[i].exp_hwm, vecs[i].exp_uf, vecs[i].exp_of, vecs[i].exp_err);
      end

      // Fill from depth 1 to full, then overflow and a refused SWAP.
      for (int k = 2; k <= DEPTH; k++) begin
         applyStimulus(1'b1, 1'b0, PUSH, 8'(k), $sformatf("fill%0d", k), 1'b1);
         checkAll($sformatf("fill%0d", k), PUSH, 8'(k), k, k, 1'b0, 1'b0, NONE);
      end
      applyStimulus(1'b1, 1'b0, PUSH, 8'hEE, "ovf", 1'b1);
      checkAll("ovf", NONE, 8'(DEPTH), DEPTH, DEPTH, 1'b0, 1'b1, PUSH);
      applyStimulus(1'b1, 1'b0, SWAP, 8'hAB, "stall", 1'b0);
      checkAll("stall", NONE, 8'(DEPTH), DEPTH, DEPTH, 1'b0, 1'b1, PUSH);
      applyStimulus(1'b0, 1'b1, NONE, 8'h00, "clr", 1'b0);
      checkAll("clr", NONE, 8'(DEPTH), DEPTH, DEPTH, 1'b0, 1'b0, NONE);

      // Async reset while a PUSH is being issued.
      applyStimulus(1'b1, 1'b0, DROP, 8'h01, "pre_drop", 1'b1);
      applyStimulus(1'b1, 1'b0, PUSH, 8'h5A, "pre_push", 1'b1);
      checkOutput("pre_rst se", 32'(o_se), 32'(PUSH));
      i_valid = 1'b0;
      #2;
      i_rst = 1'b1;
      #1;
      checkAll("async_rst", NONE, 8'h00, 0, 0, 1'b0, 1'b0, NONE);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;

      // Randomized traffic against the queue model.
      doReset();
      modelReset();
      for (int n = 0; n < 600; n++) begin
         v  = ($urandom_range(0, 9) < 8);
         c  = ($urandom_range(0, 19) == 0);
         op = ($urandom_range(0, 2) == 0) ? PUSH : 3'($urandom_range(0, 7));
         d  = 8'($urandom);
         exp_rdy = !(m_uf || m_of) && !c;
         applyStimulus(v, c, op, d, $sformatf("rnd%0d", n), exp_rdy);
         modelStep(v, c, op, d);
         checkAll($sformatf("rnd%0d", n), m_se, m_data, m_stk.size(), m_hwm, m_uf, m_of, m_err);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lifo_ctl.md
Name: lifo_ctl

Overview:
- Command-side front end for the `lifo_se` register stack: accepts stack-effect requests over a valid/ready handshake and issues `i_se`/`i_data` to the stack.
- Tracks live stack depth and issues only requests that cannot underflow or overflow the fixed-depth stack.
- Flags illegal requests with sticky error bits, reports a high-water mark, and stalls until software clears the error.

Parameters:
- WIDTH, 8, bits per data element; must match the attached `lifo_se`.
- DEPTH, 12, number of stack elements; must match the attached `lifo_se`.
- DW, $clog2(DEPTH+1), width of depth counters (derived, not overridden).

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  asynchronous reset, active-high
- i_valid  input  1  request present
- o_ready  output  1  controller can accept a request
- i_op  input  3  requested stack effect; codes from the shared stack-effect include (NONE, DROP, PUSH, RPLC, SWAP, ROT3, RROT, ALU2)
- i_data  input  WIDTH  data for PUSH/RPLC/ALU2
- o_se  output  3  stack effect issued to `lifo_se.i_se`
- o_data  output  WIDTH  data issued to `lifo_se.i_data`
- o_depth  output  DW  current number of live elements
- o_hwm  output  DW  maximum depth reached since reset/clear
- o_underflow  output  1  sticky: a request needed more elements than present
- o_overflow  output  1  sticky: PUSH requested at full depth
- o_err_op  output  3  op code of the first faulting request
- i_clr_err  input  1  clears sticky errors, o_err_op and o_hwm (o_hwm reloads to o_depth)

Behaviour:
- Reset (async): o_se=NONE, o_data=0, o_depth=0, o_hwm=0, o_underflow=0, o_overflow=0, o_err_op=NONE.
- o_ready = !(o_underflow | o_overflow) & !i_clr_err. Combinational; no dependence on i_valid.
- Accept: i_valid & o_ready on a rising edge.
- Legality and depth delta per op (d = o_depth before the request):
  - NONE: always legal, delta 0, issues NONE.
  - DROP: needs d≥1, delta -1.
  - PUSH: needs d<DEPTH, delta +1.
  - RPLC: needs d≥1, delta 0.
  - SWAP: needs d≥2, delta 0.
  - ROT3: needs d≥3, delta 0.
  - RROT: needs d≥3, delta 0.
  - ALU2: needs d≥2, delta -1.
- Legal accept: next cycle o_se=op, o_data=i_data, o_depth=d+delta. o_hwm=max(o_hwm, new depth). Latency 1 cycle; one op per cycle sustained.
- Illegal accept: o_se=NONE, o_depth unchanged, nothing reaches the stack.
  - Set o_overflow (PUSH at full depth) or o_underflow (all other cases).
  - Capture o_err_op only if no error flag was already set.
  - o_ready drops the following cycle.
- No accept: o_se=NONE next cycle. o_data holds its last value. The stack must see exactly one effect per accepted legal op.
- i_clr_err=1: next cycle flags=0, o_err_op=NONE, o_hwm=o_depth. No request is accepted that cycle. o_depth is unaffected.
- Depth never wraps: counter saturates by construction, since illegal ops never change it.
- Reset mid-stream: a pending o_se is forced to NONE immediately (async). The stack contents are don't-care after reset because depth=0.
- Unknown op codes (outside the eight above) are treated as underflow errors.

Test Plan:
- Reset, then PUSH 0x11, 0x22, 0x33 back-to-back with i_valid held → o_se=PUSH on three consecutive cycles; o_depth 1,2,3; o_hwm=3; stack s0=0x33, s1=0x22.
- From depth 3: SWAP, ROT3, ALU2 data 0x55 → o_se follows each one cycle later; depth 3,3,2; stack s0=0x55.
- From depth 0: DROP → o_se=NONE; o_underflow=1; o_err_op=DROP; o_ready=0; then a PUSH with i_valid held is not accepted and depth stays 0.
- Pulse i_clr_err with i_valid=1 → no accept that cycle; next cycle flags=0, o_hwm=o_depth, o_ready=1, and the pending PUSH is accepted.
- 12 PUSHes reach depth 12, o_hwm=12; a 13th PUSH → o_overflow=1, o_se=NONE, depth stays 12. A following SWAP is refused (stall), and o_err_op stays PUSH.
- Assert i_rst while o_se=PUSH is being driven → o_se=NONE and o_depth=0 without waiting for a clock edge; all flags 0.
